// File: rtl/two_level_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : two_level_predictor_if
// Description : Pipeline <-> branch predictor signal bundle.
// Revision    : 1.0  initial release
// ============================================================================
interface two_level_predictor_if #(
    parameter int HIST_LEN = 6
) ();
    logic                stallD;
    logic                flushD;
    logic [31:0]         pcF;
    logic [31:0]         instrD;
    logic [31:0]         pcM;
    logic                branchM;
    logic                actual_takeM;
    logic                pred_takeM;
    logic [HIST_LEN-1:0] pht_idxM;
    logic                branchD;
    logic                pred_takeD;
    logic [HIST_LEN-1:0] pht_idxD;

    modport master (
        output stallD, flushD, pcF, instrD, pcM, branchM, actual_takeM,
               pred_takeM, pht_idxM,
        input  branchD, pred_takeD, pht_idxD
    );

    modport slave (
        input  stallD, flushD, pcF, instrD, pcM, branchM, actual_takeM,
               pred_takeM, pht_idxM,
        output branchD, pred_takeD, pht_idxD
    );
endinterface
`default_nettype wire

// File: rtl/two_level_predictor.sv
`default_nettype none
// ============================================================================
// Module      : two_level_predictor
// Description : Two-level branch predictor (local / global / gshare indexing).
// Revision    : 1.0  initial release
// ============================================================================
module two_level_predictor #(
    parameter int MODE      = 2,
    parameter int HIST_LEN  = 6,
    parameter int BHT_DEPTH = 10,
    parameter int CNT_WIDTH = 2,
    parameter int PC_LSB    = 2
) (
    input  wire logic            clk,
    input  wire logic            rst,
    two_level_predictor_if.slave bus
);
    localparam int                   c_PHT_SIZE = 1 << HIST_LEN;
    localparam logic [CNT_WIDTH-1:0] c_CNT_INIT = {1'b1, {(CNT_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] r_pht [c_PHT_SIZE];
    logic [HIST_LEN-1:0]  r_specGhr;
    logic [HIST_LEN-1:0]  r_retGhr;
    logic                 r_predReg;
    logic [HIST_LEN-1:0]  r_idxReg;

    logic [HIST_LEN-1:0]  w_idxF;
    logic [HIST_LEN-1:0]  w_pcBits;
    logic [5:0]           w_opcode;
    logic                 w_predF;
    logic                 w_branchD;
    logic                 w_predTakeD;
    logic                 w_mispredict;
    logic [HIST_LEN-1:0]  w_retNext;
    logic                 w_unused;

    assign w_opcode  = bus.instrD[31:26];
    // REGIMM branches are the rt values with rt[3:1] == 000 (bltz/bgez/bltzal/bgezal).
    assign w_branchD = (w_opcode[5:2] == 4'b0001) ||
                       ((w_opcode == 6'b000001) && (bus.instrD[19:17] == 3'b000));

    assign w_pcBits     = bus.pcF[PC_LSB+HIST_LEN-1:PC_LSB];
    assign w_predF      = r_pht[w_idxF][CNT_WIDTH-1];
    assign w_predTakeD  = w_branchD & r_predReg;
    assign w_mispredict = bus.branchM & (bus.pred_takeM != bus.actual_takeM);
    assign w_retNext    = {r_retGhr[HIST_LEN-2:0], bus.actual_takeM};

    assign bus.branchD    = w_branchD;
    assign bus.pred_takeD = w_predTakeD;
    assign bus.pht_idxD   = r_idxReg;

    assign w_unused = &{1'b0, bus.pcF, bus.pcM, bus.instrD, w_pcBits};

    generate
        if (MODE == 0) begin : g_local
            localparam int c_BHT_SIZE = 1 << BHT_DEPTH;
            logic [HIST_LEN-1:0]  r_bht [c_BHT_SIZE];
            logic [BHT_DEPTH-1:0] w_bhtRdIdx;
            logic [BHT_DEPTH-1:0] w_bhtWrIdx;

            assign w_bhtRdIdx = bus.pcF[PC_LSB+BHT_DEPTH-1:PC_LSB];
            assign w_bhtWrIdx = bus.pcM[PC_LSB+BHT_DEPTH-1:PC_LSB];
            assign w_idxF     = r_bht[w_bhtRdIdx];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < c_BHT_SIZE; i++) begin
                        r_bht[i] <= '0;
                    end
                end else if (bus.branchM) begin
                    r_bht[w_bhtWrIdx] <= {r_bht[w_bhtWrIdx][HIST_LEN-2:0], bus.actual_takeM};
                end
            end
        end else if (MODE == 1) begin : g_global
            assign w_idxF = r_specGhr;
        end else begin : g_gshare
            assign w_idxF = r_specGhr ^ w_pcBits;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_PHT_SIZE; i++) begin
                r_pht[i] <= c_CNT_INIT;
            end
        end else if (bus.branchM) begin
            if (bus.actual_takeM) begin
                if (r_pht[bus.pht_idxM] != c_CNT_MAX) begin
                    r_pht[bus.pht_idxM] <= r_pht[bus.pht_idxM] + c_CNT_ONE;
                end
            end else if (r_pht[bus.pht_idxM] != '0) begin
                r_pht[bus.pht_idxM] <= r_pht[bus.pht_idxM] - c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_predReg <= 1'b0;
            r_idxReg  <= '0;
            r_retGhr  <= '0;
            r_specGhr <= '0;
        end else begin
            if (bus.flushD) begin
                r_predReg <= 1'b0;
                r_idxReg  <= '0;
            end else if (!bus.stallD) begin
                r_predReg <= w_predF;
                r_idxReg  <= w_idxF;
            end

            if (bus.branchM) begin
                r_retGhr <= w_retNext;
            end

            // A mispredict makes the ID-stage branch wrong-path, so repair wins.
            if (w_mispredict) begin
                r_specGhr <= w_retNext;
            end else if (w_branchD && !bus.stallD) begin
                r_specGhr <= {r_specGhr[HIST_LEN-2:0], w_predTakeD};
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_two_level_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_two_level_predictor
// Description : Bench for local (MODE 0) and gshare (MODE 2) predictor instances.
// Revision    : 1.0  initial release
// ============================================================================
module tb_two_level_predictor;
    localparam logic [31:0] c_BEQ = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallD = 0, flushD = 0, branchM = 0, actual_takeM = 0, pred_takeM = 0;
    logic [31:0] pcF = 0, instrD = 0, pcM = 0;
    logic [5:0]  pht_idxM = 0;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] expQ[$];
    logic [15:0] obsQ[$];

    // Reference state: index 0 models the MODE 0 instance, index 1 the MODE 2 instance.
    int         mPht  [2][64];
    logic [5:0] mBht  [1024];
    logic [5:0] mSpec [2];
    logic [5:0] mRet  [2];
    logic [5:0] mIdx  [2];
    logic       mPred [2];

    two_level_predictor_if #(.HIST_LEN(6)) bus0 ();
    two_level_predictor_if #(.HIST_LEN(6)) bus2 ();

    assign bus0.stallD = stallD;   assign bus2.stallD = stallD;
    assign bus0.flushD = flushD;   assign bus2.flushD = flushD;
    assign bus0.pcF = pcF;         assign bus2.pcF = pcF;
    assign bus0.instrD = instrD;   assign bus2.instrD = instrD;
    assign bus0.pcM = pcM;         assign bus2.pcM = pcM;
    assign bus0.branchM = branchM; assign bus2.branchM = branchM;
    assign bus0.actual_takeM = actual_takeM; assign bus2.actual_takeM = actual_takeM;
    assign bus0.pred_takeM = pred_takeM;     assign bus2.pred_takeM = pred_takeM;
    assign bus0.pht_idxM = pht_idxM;         assign bus2.pht_idxM = pht_idxM;

    two_level_predictor #(.MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    two_level_predictor #(.MODE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    function automatic logic isBranch(input logic [31:0] ins);
        logic [5:0] op;
        logic [4:0] rt;
        op = ins[31:26];
        rt = ins[20:16];
        if (op == 6'b000100 || op == 6'b000101 || op == 6'b000110 || op == 6'b000111)
            return 1'b1;
        if (op == 6'b000001 &&
            (rt == 5'b00000 || rt == 5'b00001 || rt == 5'b10000 || rt == 5'b10001))
            return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) mPht[k][i] = 2;
            mSpec[k] = 0; mRet[k] = 0; mIdx[k] = 0; mPred[k] = 0;
        end
        for (int i = 0; i < 1024; i++) mBht[i] = 0;
    endtask

    task automatic modelStep();
        logic [5:0] idxF, oldSpec, oldRet;
        logic       predF, dec, predD;
        dec = isBranch(instrD);
        for (int k = 0; k < 2; k++) begin
            idxF  = (k == 0) ? mBht[pcF[11:2]] : (mSpec[k] ^ pcF[7:2]);
            predF = (mPht[k][idxF] >= 2);
            predD = dec & mPred[k];
            oldSpec = mSpec[k];
            oldRet  = mRet[k];
            if (flushD) begin
                mPred[k] = 0; mIdx[k] = 0;
            end else if (!stallD) begin
                mPred[k] = predF; mIdx[k] = idxF;
            end
            if (branchM) begin
                if (actual_takeM) begin
                    if (mPht[k][pht_idxM] < 3) mPht[k][pht_idxM]++;
                end else if (mPht[k][pht_idxM] > 0) mPht[k][pht_idxM]--;
                if (k == 0) mBht[pcM[11:2]] = {mBht[pcM[11:2]][4:0], actual_takeM};
                mRet[k] = {oldRet[4:0], actual_takeM};
            end
            if (branchM && (pred_takeM != actual_takeM))
                mSpec[k] = {oldRet[4:0], actual_takeM};
            else if (dec && !stallD)
                mSpec[k] = {oldSpec[4:0], predD};
        end
    endtask

    // Push model expectation and DUT observation for the current inputs, then clock.
    task automatic cycle();
        logic dec;
        #1;
        dec = isBranch(instrD);
        expQ.push_back({dec, dec & mPred[0], mIdx[0], dec, dec & mPred[1], mIdx[1]});
        obsQ.push_back({bus0.branchD, bus0.pred_takeD, bus0.pht_idxD,
                        bus2.branchD, bus2.pred_takeD, bus2.pht_idxD});
        @(posedge clk);
        if (rst) modelStep(); else modelReset();
        #1;
    endtask

    task automatic idle();
        stallD = 0; flushD = 0; branchM = 0; actual_takeM = 0; pred_takeM = 0;
        instrD = 0;
    endtask

    task automatic test_reset();
        logic [15:0] e, o;
        modelReset();
        idle();
        cycle();
        cycle();
        compared++;
        if ({bus2.pred_takeD, bus2.pht_idxD, bus0.pred_takeD, bus0.pht_idxD} !== 14'h0) begin
            mismatched++;
            $display("FAIL reset_outputs got=%h want=0",
                     {bus2.pred_takeD, bus2.pht_idxD, bus0.pred_takeD, bus0.pht_idxD});
        end
        rst = 1'b1;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL reset_vec got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_defaults();
        logic [15:0] e, o;
        pcF = 32'h100; cycle();
        instrD = c_BEQ; #1;
        compared++;
        if ({bus2.branchD, bus2.pred_takeD, bus2.pht_idxD} !== 8'b1_1_000000) begin
            mismatched++;
            $display("FAIL default_pred got=%b want=11000000",
                     {bus2.branchD, bus2.pred_takeD, bus2.pht_idxD});
        end
        cycle();
        instrD = 0; cycle();
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL default_vec got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_saturate();
        logic [15:0] e, o;
        pcF = 32'h104; pcM = 0; pht_idxM = 0;
        branchM = 1; actual_takeM = 0; pred_takeM = 0;
        repeat (3) cycle();
        idle(); instrD = c_BEQ; #1;
        compared++;
        if ({bus2.pred_takeD, bus2.pht_idxD, bus0.pred_takeD, bus0.pht_idxD} !== 14'h0) begin
            mismatched++;
            $display("FAIL saturate_low got=%h want=0",
                     {bus2.pred_takeD, bus2.pht_idxD, bus0.pred_takeD, bus0.pht_idxD});
        end
        cycle();
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL saturate_vec got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_spec_history();
        logic [15:0] e, o;
        pcF = 32'h100; instrD = c_BEQ; cycle();
        stallD = 1; cycle(); cycle();
        stallD = 0; flushD = 1; cycle();
        flushD = 0; #1;
        compared++;
        if ({bus2.pred_takeD, bus2.pht_idxD} !== 7'h0) begin
            mismatched++;
            $display("FAIL flush_clear got=%h want=0", {bus2.pred_takeD, bus2.pht_idxD});
        end
        cycle();
        idle(); cycle();
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL spec_vec got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_repair();
        logic [15:0] e, o;
        // Rebuild ret_ghr to a known value: all zeros, then shift in 1,1.
        pcM = 0; pht_idxM = 5; branchM = 1; pred_takeM = 0; actual_takeM = 0;
        repeat (6) cycle();
        pred_takeM = 1; actual_takeM = 1;
        repeat (2) cycle();
        actual_takeM = 0; instrD = c_BEQ; cycle();
        idle(); pcF = 0; cycle();
        #1;
        compared++;
        if (bus2.pht_idxD !== 6'b000110) begin
            mismatched++;
            $display("FAIL repair_ghr got=%b want=000110", bus2.pht_idxD);
        end
        cycle();
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL repair_vec got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_local();
        logic [15:0] e, o;
        pcM = 32'h40; pht_idxM = 9; branchM = 1; pred_takeM = 1; actual_takeM = 1;
        repeat (3) cycle();
        idle(); pcF = 32'h40; cycle();
        instrD = c_BEQ; #1;
        compared++;
        if ({bus0.pred_takeD, bus0.pht_idxD} !== 7'b1_000111) begin
            mismatched++;
            $display("FAIL local_index got=%b want=1000111", {bus0.pred_takeD, bus0.pht_idxD});
        end
        cycle();
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL local_vec got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_decode();
        logic [31:0] ins [7] = '{32'h0000_0020, 32'h0401_0000, 32'h0402_0000, 32'h1C00_0000,
                                 32'h2000_0000, 32'h0411_0000, 32'h1400_0000};
        logic        want [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [15:0] e, o;
        for (int i = 0; i < 7; i++) begin
            instrD = ins[i]; #1;
            compared++;
            if (bus0.branchD !== want[i] || bus2.branchD !== want[i] ||
                (!want[i] && (bus0.pred_takeD !== 1'b0))) begin
                mismatched++;
                $display("FAIL decode_%0d got=%b%b%b want=%b%b0", i, bus0.branchD,
                         bus2.branchD, bus0.pred_takeD, want[i], want[i]);
            end
            cycle();
        end
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL decode_vec got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [5] = '{c_BEQ, 32'h0400_0000, 32'h0000_0020, 32'h1400_0000,
                                 32'h8C00_0000};
        logic [15:0] e, o;
        for (int n = 0; n < 300; n++) begin
            pcF = $urandom(); pcM = $urandom();
            instrD = ins[$urandom_range(0, 4)];
            stallD = ($urandom_range(0, 3) == 0);
            flushD = ($urandom_range(0, 5) == 0);
            branchM = $urandom_range(0, 1);
            actual_takeM = $urandom_range(0, 1);
            pred_takeM = $urandom_range(0, 1);
            pht_idxM = 6'($urandom_range(0, 63));
            cycle();
        end
        idle();
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL stress_vec got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] e, o;
        // Train PHT entries away from weakly-taken so the reset has something to undo.
        branchM = 1; actual_takeM = 0; pred_takeM = 0;
        for (int i = 0; i < 64; i++) begin pht_idxM = 6'(i); cycle(); cycle(); end
        idle(); pcF = 32'h40; instrD = c_BEQ;
        rst = 1'b0; #1;
        compared++;
        if ({bus0.pred_takeD, bus0.pht_idxD, bus2.pred_takeD, bus2.pht_idxD} !== 14'h0) begin
            mismatched++;
            $display("FAIL async_reset got=%h want=0",
                     {bus0.pred_takeD, bus0.pht_idxD, bus2.pred_takeD, bus2.pht_idxD});
        end
        modelReset();
        cycle();
        rst = 1'b1; instrD = 0; pcF = 32'h100; cycle();
        instrD = c_BEQ; #1;
        compared++;
        if ({bus0.pred_takeD, bus2.pred_takeD} !== 2'b11) begin
            mismatched++;
            $display("FAIL reset_pht got=%b want=11", {bus0.pred_takeD, bus2.pred_takeD});
        end
        cycle();
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL areset_vec got=%h want=%h", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_saturate();
        test_spec_history();
        test_repair();
        test_local();
        test_decode();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/two_level_predictor.md
Name: two_level_predictor

Overview:
Parametrised two-level dynamic branch predictor. It predicts in IF, delivers the prediction in ID and trains in MEM.
- MODE selects the indexing scheme: local (per-PC history table), global (GHR) or gshare (GHR xor PC).
- Pattern table holds N-bit saturating counters.
- A speculative global history is repaired on a MEM-stage mispredict.
- The PHT index used for each prediction travels down the pipeline with the branch, so training hits the exact counter that made the prediction.

Parameters:
MODE, 2, indexing scheme: 0 local, 1 global, 2 gshare
HIST_LEN, 6, history bits; PHT has 2^HIST_LEN entries
BHT_DEPTH, 10, log2 of local history table entries (used in MODE 0 only)
CNT_WIDTH, 2, saturating counter width, minimum 2
PC_LSB, 2, lowest PC bit used for indexing

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
stallD  input  1  hold the IF/ID prediction register
flushD  input  1  clear the IF/ID prediction register
pcF  input  32  fetch PC
instrD  input  32  instruction in ID
pcM  input  32  PC of the instruction in MEM
branchM  input  1  MEM instruction is a conditional branch
actual_takeM  input  1  resolved branch direction
pred_takeM  input  1  prediction carried with the MEM branch
pht_idxM  input  HIST_LEN  PHT index carried with the MEM branch
branchD  output  1  ID instruction is a conditional branch
pred_takeD  output  1  predicted direction in ID
pht_idxD  output  HIST_LEN  PHT index of the ID prediction, for the pipeline to carry forward

Behaviour:
- Reset (rst=0, asynchronous):
  - every PHT counter = 2^(CNT_WIDTH-1) (weakly taken);
  - all BHT entries, spec_ghr and ret_ghr = 0;
  - prediction register = 0, so pred_takeD=0 and pht_idxD=0.
- Branch decode (combinational) on instrD[31:26]:
  - 000100 / 000101 / 000110 / 000111 -> branchD=1;
  - 000001 with rt (instrD[20:16]) in {00000, 00001, 10000, 10001} -> branchD=1;
  - anything else -> branchD=0.
- F-stage index (combinational), pcbits = pcF[PC_LSB+HIST_LEN-1:PC_LSB]:
  - MODE 0: BHT[pcF[PC_LSB+BHT_DEPTH-1:PC_LSB]];
  - MODE 1: spec_ghr;
  - MODE 2: spec_ghr ^ pcbits.
- pred_takeF = MSB of PHT[idxF].
- IF/ID register {pred, idx}:
  - flushD -> cleared to 0 (flush beats stall);
  - else if !stallD -> loads {pred_takeF, idxF};
  - else holds.
- Outputs: pred_takeD = branchD & pred_reg; pht_idxD = idx_reg. Latency: one cycle from pcF to prediction.
- PHT training, only when branchM=1, on entry PHT[pht_idxM]:
  - increment if actual_takeM, saturating at 2^CNT_WIDTH-1;
  - decrement otherwise, saturating at 0.
- Read/write same entry in the same cycle: the F-stage read returns the pre-update value.
- BHT training (MODE 0), when branchM=1:
  - BHT[pcM index] <= {old[HIST_LEN-2:0], actual_takeM};
  - same-cycle read returns the old value.
- ret_ghr: when branchM=1, ret_ghr <= {ret_ghr[HIST_LEN-2:0], actual_takeM}.
- spec_ghr, in priority order:
  1. mispredict (branchM & (pred_takeM != actual_takeM)) -> spec_ghr <= updated ret_ghr value, i.e. {ret_ghr[HIST_LEN-2:0], actual_takeM};
  2. else branchD & !stallD -> spec_ghr <= {spec_ghr[HIST_LEN-2:0], pred_takeD};
  3. else hold.
- Repair discards the same-cycle ID branch update, since that instruction is wrong-path.
- The GHRs are kept in all modes; in MODE 0 they have no effect on prediction.
- flushD does not block the spec_ghr update: flushD kills the instruction entering ID, not the one in ID.
- History wrap: shift registers drop their MSB; the PHT index wraps naturally modulo 2^HIST_LEN.

Test Plan:
1. Defaults (MODE 2). Release reset, pcF=0x100, next cycle instrD=beq (0x10000000), no stall -> branchD=1, pred_takeD=1, pht_idxD=0.
2. Three branchM updates, pht_idxM=0, actual_takeM=0 -> counter 2'b10 -> 01 -> 00 -> 00 (saturates). Re-fetch pcF=0x100 -> pred_takeD=0.
3. Speculative history:
   - spec_ghr=0, branchD=1, pred_takeD=1, stallD=0 -> spec_ghr=6'b000001;
   - repeat with stallD=1 -> unchanged;
   - flushD=1 with stallD=0 -> reg cleared next cycle, pred_takeD=0.
4. Repair: ret_ghr=6'b000011, branchM=1, pred_takeM=1, actual_takeM=0, plus same-cycle branchD=1 with pred 1 -> ret_ghr = spec_ghr = 6'b000110.
5. MODE 0: pcM=0x40 resolved taken three times -> BHT[16]=6'b000111. Then pcF=0x40 -> pht_idxD=7, and PHT[7] is still at reset value, so pred_takeD=1.
6. Decode:
   - instrD=0x00000020 (add) -> branchD=0, pred_takeD=0 even with pred_reg=1;
   - opcode 000001 with rt=00001 (bgez) -> branchD=1;
   - rt=00010 -> branchD=0.
7. Assert rst=0 between clock edges mid-operation -> all outputs 0 immediately; PHT entries return to 2'b10.
